// File: rtl/mux_8to1_rr_pkg.sv
// Shared definitions for the round-robin 8-to-1 packet multiplexer.
package mux_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;
endpackage

// File: rtl/mux_8to1_rr_arb.sv
// Combinational rotating-priority arbiter: first requester at or above i_ptr, wrapping 7->0.
module rr_arb8
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  logic [CH_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // 3-bit addition wraps naturally past channel 7
      w_cand = i_ptr + CH_W'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mux_8to1_rr.sv
// Packet-aware round-robin 8-to-1 mux with a registered output stage and source index.
module mux_8to1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_sel,
  input  logic                     out_ready
);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CH_W-1:0]   r_lch, w_lch_nxt;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_free;
  logic              w_acc;
  logic              w_last;
  logic [DATA_W-1:0] w_data;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [CH_W-1:0]   r_out_sel;

  // While locked, masking requests down to the owner makes the arbiter grant only it
  always_comb begin
    w_req = in_valid;
    if (r_state == ST_LOCKED) begin
      w_req = in_valid & ({{(NUM_CH-1){1'b0}}, 1'b1} << r_lch);
    end
  end

  rr_arb8 u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_free   = !r_out_valid || out_ready;
  assign w_acc    = w_free && w_any;
  assign in_ready = w_free ? w_gnt : '0;
  assign w_data   = in_data[w_idx*DATA_W +: DATA_W];
  assign w_last   = in_last[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_lch   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lch   <= w_lch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lch_nxt   = r_lch;
    if (w_acc) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = w_idx + CH_W'(1);
      end else begin
        w_state_nxt = ST_LOCKED;
        w_lch_nxt   = w_idx;
      end
    end
  end

  // Output stage: a new beat overwrites a draining one, so no bubble at full rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_sel   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule
